sdr_sdram_wb_arb: RTL and testbench

//  Round-robin arbiter that shares the single Wishbone slave port of the SDR SDRAM

---
 rtl/sdr_sdram_wb_arb_pkg.sv | 23 ++
 rtl/sdr_sdram_wb_arb_rr_pick.sv | 27 ++
 rtl/sdr_sdram_wb_arb.sv | 119 +++++++++++
 tb/tb_sdr_sdram_wb_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_sdram_wb_arb_pkg.sv
// Shared Wishbone constants and arbiter state type for the SDRAM slave-port arbiter.
package sdr_sdram_wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_BEAT4   = 2'b01;
  localparam logic [1:0] BTE_BEAT8   = 2'b10;
  localparam logic [1:0] BTE_BEAT16  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // An ack on a classic or end-of-burst beat completes the owner's cycle.
  function automatic logic cti_ends_cycle(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/sdr_sdram_wb_arb_rr_pick.sv
// Combinational one-hot round-robin picker: scans last+1, last+2, ... (mod NR).
module wb_rr_pick #(
  parameter int unsigned NR = 4,
  parameter int unsigned LW = 2
) (
  input  logic [NR-1:0] req_i,
  input  logic [LW-1:0] last_i,
  output logic [NR-1:0] gnt_o
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NR; off++) begin
      idx = LW'((32'(last_i) + off) % NR);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdr_sdram_wb_arb.sv
// Round-robin arbiter sharing the SDRAM controller's Wishbone slave port among
// several masters; a grant is held for a whole cycle or burst.
module sdr_sdram_wb_arb
  import sdr_sdram_wb_arb_pkg::*;
#(
  parameter int unsigned nr_masters = 4,
  parameter int unsigned adr_size   = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [32*nr_masters-1:0]       m_dat_i,
  input  logic [adr_size*nr_masters-1:0] m_adr_i,
  input  logic [4*nr_masters-1:0]        m_sel_i,
  input  logic [3*nr_masters-1:0]        m_cti_i,
  input  logic [2*nr_masters-1:0]        m_bte_i,
  input  logic [nr_masters-1:0]          m_we_i,
  input  logic [nr_masters-1:0]          m_cyc_i,
  input  logic [nr_masters-1:0]          m_stb_i,
  output logic [31:0]                    m_dat_o,
  output logic [nr_masters-1:0]          m_ack_o,
  output logic [31:0]                    s_dat_o,
  output logic [adr_size-1:0]            s_adr_o,
  output logic [3:0]                     s_sel_o,
  output logic [2:0]                     s_cti_o,
  output logic [1:0]                     s_bte_o,
  output logic                           s_we_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  input  logic [31:0]                    s_dat_i,
  input  logic                           s_ack_i,
  output logic [nr_masters-1:0]          gnt
);

  localparam int unsigned LW = (nr_masters > 1) ? $clog2(nr_masters) : 1;

  arb_state_e              state_q, state_d;
  logic [nr_masters-1:0]   gnt_q, gnt_d;
  logic [LW-1:0]           last_q, last_d;
  logic [nr_masters-1:0]   pick_gnt;
  logic [LW-1:0]           own_idx;

  wb_rr_pick #(
    .NR (nr_masters),
    .LW (LW)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  // AND-OR slave-side mux on the registered one-hot grant; no grant gives all zeros.
  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    own_idx = '0;
    for (int unsigned k = 0; k < nr_masters; k++) begin
      s_dat_o = s_dat_o | (m_dat_i[k*32 +: 32]             & {32{gnt_q[k]}});
      s_adr_o = s_adr_o | (m_adr_i[k*adr_size +: adr_size] & {adr_size{gnt_q[k]}});
      s_sel_o = s_sel_o | (m_sel_i[k*4 +: 4]               & {4{gnt_q[k]}});
      s_cti_o = s_cti_o | (m_cti_i[k*3 +: 3]               & {3{gnt_q[k]}});
      s_bte_o = s_bte_o | (m_bte_i[k*2 +: 2]               & {2{gnt_q[k]}});
      s_we_o  = s_we_o  | (m_we_i[k]  & gnt_q[k]);
      s_cyc_o = s_cyc_o | (m_cyc_i[k] & gnt_q[k]);
      s_stb_o = s_stb_o | (m_stb_i[k] & gnt_q[k]);
      if (gnt_q[k]) begin
        own_idx = LW'(k);
      end
    end
  end

  // Acks reach only an owner that still holds cyc.
  assign m_ack_o = gnt_q & m_cyc_i & {nr_masters{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign gnt     = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = pick_gnt;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!s_cyc_o || (s_ack_i && cti_ends_cycle(s_cti_o))) begin
          gnt_d   = '0;
          last_d  = own_idx;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(nr_masters - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sdr_sdram_wb_arb.sv
// Directed self-checking bench for the round-robin SDRAM Wishbone arbiter.
module tb_sdr_sdram_wb_arb;
  import sdr_sdram_wb_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 24;

  logic              clk;
  logic              rst_n;
  logic [32*NR-1:0]  m_dat_i;
  logic [AW*NR-1:0]  m_adr_i;
  logic [4*NR-1:0]   m_sel_i;
  logic [3*NR-1:0]   m_cti_i;
  logic [2*NR-1:0]   m_bte_i;
  logic [NR-1:0]     m_we_i;
  logic [NR-1:0]     m_cyc_i;
  logic [NR-1:0]     m_stb_i;
  logic [31:0]       m_dat_o;
  logic [NR-1:0]     m_ack_o;
  logic [31:0]       s_dat_o;
  logic [AW-1:0]     s_adr_o;
  logic [3:0]        s_sel_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic              s_we_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i;
  logic [NR-1:0]     gnt;

  int n_cmp;
  int n_bad;

  sdr_sdram_wb_arb #(
    .nr_masters (NR),
    .adr_size   (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_dat_i (m_dat_i),
    .m_adr_i (m_adr_i),
    .m_sel_i (m_sel_i),
    .m_cti_i (m_cti_i),
    .m_bte_i (m_bte_i),
    .m_we_i  (m_we_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .s_dat_o (s_dat_o),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_cti_o (s_cti_o),
    .s_bte_o (s_bte_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt     (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] adr_of(input int k);
    return AW'((k + 1) << 20) | AW'(24'h000040);
  endfunction

  function automatic logic [31:0] dat_of(input int k);
    return 32'hD000_0000 | 32'(k);
  endfunction

  function automatic logic [NR-1:0] oh(input int k);
    return NR'(1) << k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cti(input int k, input logic [2:0] cti);
    m_cti_i[k*3 +: 3] = cti;
  endtask

  task automatic set_req(input int k, input logic on);
    m_cyc_i[k] = on;
    m_stb_i[k] = on;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_gnt cycle %0d: got %b want 0000", c, gnt);
      end
      n_cmp++;
      if (s_cyc_o !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_s_cyc cycle %0d: got %b want 0", c, s_cyc_o);
      end
      n_cmp++;
      if (s_adr_o !== '0) begin
        n_bad++;
        $display("FAIL reset_s_adr cycle %0d: got %h want 000000", c, s_adr_o);
      end
    end
  endtask

  task automatic test_all_request();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 4; k++) begin
      set_req(k, 1'b1);
      set_cti(k, CTI_CLASSIC);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (gnt !== oh(order[i])) begin
        n_bad++;
        $display("FAIL rr_gnt step %0d: got %b want %b", i, gnt, oh(order[i]));
      end
      n_cmp++;
      if (s_adr_o !== adr_of(order[i]) || s_dat_o !== dat_of(order[i]) || s_cyc_o !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_mux step %0d: adr %h dat %h cyc %b want adr %h dat %h cyc 1",
                 i, s_adr_o, s_dat_o, s_cyc_o, adr_of(order[i]), dat_of(order[i]));
      end
      s_ack_i = 1'b1;
      #1;
      n_cmp++;
      if (m_ack_o !== oh(order[i])) begin
        n_bad++;
        $display("FAIL rr_ack step %0d: got %b want %b", i, m_ack_o, oh(order[i]));
      end
      tick();
      s_ack_i = 1'b0;
      n_cmp++;
      if (gnt !== 4'b0000 || s_cyc_o !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_idle step %0d: gnt %b cyc %b want 0000 0", i, gnt, s_cyc_o);
      end
      if (i == 4) begin
        for (int k = 0; k < 4; k++) set_req(k, 1'b0);
      end
    end
  endtask

  task automatic test_burst();
    set_req(2, 1'b1);
    set_cti(2, CTI_INCR);
    m_bte_i[5:4] = BTE_BEAT4;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || s_bte_o !== BTE_BEAT4 || s_cti_o !== CTI_INCR) begin
      n_bad++;
      $display("FAIL burst_gnt: gnt %b bte %b cti %b want 0100 01 010", gnt, s_bte_o, s_cti_o);
    end
    set_req(1, 1'b1);
    set_cti(1, CTI_CLASSIC);
    s_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_cti(2, (b == 3) ? CTI_EOB : CTI_INCR);
      #1;
      n_cmp++;
      if (m_ack_o !== 4'b0100) begin
        n_bad++;
        $display("FAIL burst_ack beat %0d: got %b want 0100", b, m_ack_o);
      end
      tick();
      if (b < 3) begin
        n_cmp++;
        if (gnt !== 4'b0100) begin
          n_bad++;
          $display("FAIL burst_hold beat %0d: got %b want 0100", b, gnt);
        end
      end
    end
    s_ack_i = 1'b0;
    set_req(2, 1'b0);
    set_cti(2, CTI_CLASSIC);
    m_bte_i[5:4] = BTE_LINEAR;
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL burst_release: got %b want 0000", gnt);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || s_adr_o !== adr_of(1)) begin
      n_bad++;
      $display("FAIL burst_next: gnt %b adr %h want 0010 %h", gnt, s_adr_o, adr_of(1));
    end
    s_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (m_ack_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL burst_next_ack: got %b want 0010", m_ack_o);
    end
    tick();
    s_ack_i = 1'b0;
    set_req(1, 1'b0);
    tick();
  endtask

  task automatic test_drop_with_ack();
    set_req(0, 1'b1);
    set_cti(0, CTI_CLASSIC);
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL drop_gnt: got %b want 0001", gnt);
    end
    set_req(0, 1'b0);
    s_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (m_ack_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL drop_ack: got %b want 0000", m_ack_o);
    end
    tick();
    s_ack_i = 1'b0;
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL drop_release: got %b want 0000", gnt);
    end
  endtask

  task automatic test_idle_ack();
    s_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (m_ack_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_ack: got %b want 0000", m_ack_o);
    end
    tick();
    n_cmp++;
    if (m_ack_o !== 4'b0000 || gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_ack_next: ack %b gnt %b want 0000 0000", m_ack_o, gnt);
    end
    s_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    set_req(3, 1'b1);
    set_cti(3, CTI_INCR);
    tick();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_bad++;
      $display("FAIL m3_gnt: got %b want 1000", gnt);
    end
    s_ack_i = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_bad++;
      $display("FAIL m3_hold: got %b want 1000", gnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || s_cyc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: gnt %b cyc %b want 0000 0", gnt, s_cyc_o);
    end
    s_ack_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(k, 1'b1);
      set_cti(k, CTI_CLASSIC);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL post_reset_gnt: got %b want 0001", gnt);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = 4'b0101;
    m_cti_i = '0;
    m_bte_i = '0;
    s_ack_i = 1'b0;
    s_dat_i = 32'hCAFE_0001;
    for (int k = 0; k < 4; k++) begin
      m_adr_i[k*AW +: AW] = adr_of(k);
      m_dat_i[k*32 +: 32] = dat_of(k);
      m_sel_i[k*4 +: 4]   = 4'hF;
    end
    test_reset();
    test_all_request();
    test_burst();
    test_drop_with_ack();
    test_idle_ack();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
